adc_sample_framer: RTL and testbench

ADC_SAMPLE_FRAMER -- requirements
Module: adc_sample_framer

---
 rtl/adc_pkg.sv | 15 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/adc_sample_framer.sv | 146 ++++++++++++++
 tb/tb_adc_sample_framer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample framer: FSM encoding and the fixed
// per-frame overhead (sync byte, sequence byte, checksum byte).
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } frm_state_e;

  localparam int FRAME_OVERHEAD = 3;
  localparam int SEQ_W          = 8;
  localparam int DROP_W         = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output. A write is
// accepted when full only if a read retires the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  wr_accept_o,
  output logic [DEPTH_BITS:0]   level_o
);

  localparam int                  DEPTH_N  = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] LVL_FULL = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] LVL_ONE  = (DEPTH_BITS+1)'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH_N];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  full, empty, do_wr, do_rd;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign do_rd = rd_en_i && !empty;
  assign do_wr = wr_en_i && (!full || do_rd);

  assign wr_accept_o = do_wr;
  assign level_o     = level_q;
  assign rd_data_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    unique case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only; stale contents are unreachable after a pointer reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Buffers ADC samples and ships them to a UART as framed packets:
// SYNC, seq, FRAME_LEN payload samples, 8-bit additive checksum.
module adc_sample_framer
  import adc_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    FIFO_DEPTH_BITS = 5,
  parameter int                    FRAME_LEN       = 16,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [DATA_WIDTH-1:0]      sample_data,
  output logic [DATA_WIDTH-1:0]      tx_byte,
  output logic                       tx_dv,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int                       IDX_W        = $clog2(FRAME_LEN + FRAME_OVERHEAD);
  localparam logic [IDX_W-1:0]         IDX_SEQ      = IDX_W'(1);
  localparam logic [IDX_W-1:0]         IDX_PAY_LAST = IDX_W'(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0]         IDX_CSUM     = IDX_W'(FRAME_LEN + FRAME_OVERHEAD - 1);
  localparam logic [FIFO_DEPTH_BITS:0] FRAME_LVL    = (FIFO_DEPTH_BITS+1)'(FRAME_LEN);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  frm_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SEQ_W-1:0]      seq_q, seq_d;
  logic [7:0]            csum_q, csum_d;
  logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  wr_accept, pop, drop, is_payload;

  sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (sample_valid),
    .wr_data_i   (sample_data),
    .rd_en_i     (pop),
    .rd_data_o   (fifo_head),
    .wr_accept_o (wr_accept),
    .level_o     (fifo_level)
  );

  assign drop       = sample_valid && !wr_accept;
  assign is_payload = (idx_q > IDX_SEQ) && (idx_q <= IDX_PAY_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    csum_d    = csum_q;
    tx_byte_d = tx_byte_q;
    cur_byte  = '0;
    pop       = 1'b0;
    tx_dv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A frame only starts with every payload sample already buffered.
        if (fifo_level >= FRAME_LVL && !tx_active) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
        end
      end
      ST_ISSUE: begin
        tx_dv   = 1'b1;
        state_d = ST_WAIT;
        if (idx_q == '0) begin
          cur_byte = SYNC_BYTE;
        end else if (idx_q == IDX_SEQ) begin
          cur_byte = DATA_WIDTH'(seq_q);
          csum_d   = seq_q;
        end else if (is_payload) begin
          cur_byte = fifo_head;
          pop      = 1'b1;
          csum_d   = csum_q + fifo_head[7:0];
        end else begin
          cur_byte = DATA_WIDTH'(csum_q);
          seq_d    = seq_q + 8'd1;
        end
        tx_byte_d = cur_byte;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (idx_q != IDX_CSUM) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // The issued byte is shown combinationally in ISSUE and held afterwards.
  assign tx_byte    = (state_q == ST_ISSUE) ? cur_byte : tx_byte_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      csum_q     <= '0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      csum_q     <= csum_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Randomized bench for adc_sample_framer: a queue-based frame model plus a
// simple UART responder, with directed scenarios for the key corner cases.
module tb_adc_sample_framer;

  localparam int         DB    = 2;
  localparam int         FL    = 4;
  localparam int         DEPTH = 1 << DB;
  localparam int         LAST  = FL + 2;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst, sample_valid, tx_dv, tx_active, tx_done, overflow;
  logic [7:0]    sample_data, tx_byte;
  logic [DB:0]   fifo_level;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  adc_sample_framer #(
    .DATA_WIDTH      (8),
    .FIFO_DEPTH_BITS (DB),
    .FRAME_LEN       (FL),
    .SYNC_BYTE       (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .tx_byte      (tx_byte),
    .tx_dv        (tx_dv),
    .tx_active    (tx_active),
    .tx_done      (tx_done),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] q_model[$];
  int         m_level, m_drops, m_pos, frame_idx;
  logic [7:0] m_seq, m_sum, m_last;
  bit         m_ovf, m_busy, m_wait, m_dv_next;
  // UART responder and stimulus knobs
  bit         u_busy, hold_done, spur_done, rst_req, rst_at3, rst_fired;
  bit         wr_on_pop, wrpop_seen, wrap_seen;
  int         u_timer, d_min, d_max, sv_pct, ext_busy_pct, feed_n;
  logic [7:0] dir_q[$];
  logic [7:0] log_q[$];

  task automatic model_reset();
    q_model.delete();
    m_level = 0; m_drops = 0; m_pos = 0; frame_idx = 0;
    m_seq = 8'h00; m_sum = 8'h00; m_last = 8'h00;
    m_ovf = 1'b0; m_busy = 1'b0; m_wait = 1'b0; m_dv_next = 1'b0;
    u_busy = 1'b0; u_timer = 0;
  endtask

  task automatic cycle();
    bit         exp_dv, pop, acc, start_ok;
    logic [7:0] exp_b;
    @(posedge clk); #1;
    exp_dv = m_dv_next;
    pop    = 1'b0;
    check("tx_dv", tx_dv, exp_dv);
    if (exp_dv) begin
      if (m_pos == 0) begin
        exp_b = SYNC;
        frame_idx++;
      end else if (m_pos == 1) begin
        exp_b = m_seq;
        m_sum = m_seq;
        if (frame_idx == 257) begin
          check("seq_wrap", tx_byte, 0);
          wrap_seen = 1'b1;
        end
      end else if (m_pos <= FL + 1) begin
        exp_b = q_model.pop_front();
        m_sum = m_sum + exp_b;
        pop   = 1'b1;
      end else begin
        exp_b = m_sum;
        m_seq = m_seq + 8'd1;
      end
      check("tx_byte", tx_byte, exp_b);
      log_q.push_back(tx_byte);
      m_last  = exp_b;
      m_wait  = 1'b1;
      u_busy  = 1'b1;
      u_timer = $urandom_range(d_max, d_min);
    end else begin
      check("tx_byte_hold", tx_byte, m_last);
    end
    check("fifo_level", fifo_level, m_level);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);

    // Inputs for this cycle
    rst     = rst_req;
    rst_req = 1'b0;
    if (rst_at3 && m_busy && m_pos == 2 && m_wait && !exp_dv) begin
      rst       = 1'b1;
      rst_at3   = 1'b0;
      rst_fired = 1'b1;
    end
    sample_data = 8'($urandom);
    if (dir_q.size() > 0) begin
      sample_valid = 1'b1;
      sample_data  = dir_q.pop_front();
    end else if (wr_on_pop && pop) begin
      sample_valid = 1'b1;
      wr_on_pop    = 1'b0;
      wrpop_seen   = 1'b1;
    end else if (feed_n > 0 && m_level < DEPTH) begin
      sample_valid = 1'b1;
      feed_n--;
    end else begin
      sample_valid = ($urandom_range(99, 0) < sv_pct);
    end
    tx_done = 1'b0;
    if (u_busy && !exp_dv) begin
      u_timer--;
      if (u_timer <= 0 && !hold_done) begin
        tx_done = 1'b1;
        u_busy  = 1'b0;
      end
    end
    if (spur_done) begin
      tx_done   = 1'b1;
      spur_done = 1'b0;
    end
    tx_active = u_busy || tx_done || ($urandom_range(99, 0) < ext_busy_pct);

    // Model next state from this cycle's inputs
    if (rst) begin
      model_reset();
    end else begin
      acc = sample_valid && (m_level < DEPTH || pop);
      if (sample_valid && !acc) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (acc) q_model.push_back(sample_data);
      start_ok  = !m_busy && (m_level >= FL) && !tx_active;
      m_level   = m_level + int'(acc) - int'(pop);
      m_dv_next = 1'b0;
      if (start_ok) begin
        m_busy    = 1'b1;
        m_pos     = 0;
        m_dv_next = 1'b1;
      end else if (m_busy && m_wait && !exp_dv && tx_done) begin
        m_wait = 1'b0;
        if (m_pos < LAST) begin
          m_pos++;
          m_dv_next = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int max);
    int i = 0;
    while (i < max && !(dir_q.size() == 0 && feed_n == 0 && !m_busy && !m_dv_next && m_level < FL)) begin
      cycle();
      i++;
    end
    check("drain_in_budget", i < max, 1);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    cycle();
    cycle();
    check("rst_level", fifo_level, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drops", drop_count, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp37[7];
    int         i;
    exp37 = '{8'hA5, 8'h00, 8'h0A, 8'h14, 8'h1E, 8'h28, 8'h64};
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0; tx_active = 1'b0; tx_done = 1'b0;
    hold_done = 0; spur_done = 0; rst_req = 0; rst_at3 = 0; rst_fired = 0;
    wr_on_pop = 0; wrpop_seen = 0; wrap_seen = 0;
    d_min = 1; d_max = 1; sv_pct = 0; ext_busy_pct = 0; feed_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    check("init_level", fifo_level, 0);
    check("init_tx_dv", tx_dv, 0);
    check("init_tx_byte", tx_byte, 0);
    check("init_drops", drop_count, 0);

    // Single directed frame with a slow UART
    d_min = 5; d_max = 5;
    log_q.delete();
    dir_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    run(2);
    drain(300);
    check("frame1_len", log_q.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < log_q.size()) check("frame1_byte", log_q[k], exp37[k]);

    // Three frames back to back, sequence counting on from 01
    d_min = 1; d_max = 2;
    log_q.delete();
    feed_n = 3 * FL;
    run(2);
    drain(600);
    check("b2b_len", log_q.size(), 21);
    for (int f = 0; f < 3; f++) begin
      if (7 * f + 1 < log_q.size()) begin
        check("b2b_sync", log_q[7*f], SYNC);
        check("b2b_seq", log_q[7*f+1], f + 1);
      end
    end

    // Random traffic with UART back-pressure
    d_min = 1; d_max = 4; sv_pct = 40; ext_busy_pct = 15;
    run(800);
    sv_pct = 0; ext_busy_pct = 0;
    drain(400);

    // Sequence wrap: 257 frames after reset
    do_reset();
    d_min = 1; d_max = 1; sv_pct = 100;
    i = 0;
    while (i < 6000 && !(frame_idx >= 257 && m_pos >= 2)) begin
      cycle();
      i++;
    end
    check("wrap_seen", wrap_seen, 1);
    sv_pct = 0;
    drain(400);

    // Overflow with the UART stalled, then write-while-full with a pop
    do_reset();
    hold_done = 1;
    dir_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    run(12);
    check("ovf_level", fifo_level, 4);
    check("ovf_drops", drop_count, 2);
    check("ovf_flag", overflow, 1);
    wr_on_pop = 1; hold_done = 0;
    i = 0;
    while (i < 60 && !wrpop_seen) begin
      cycle();
      i++;
    end
    check("wrpop_reached", wrpop_seen, 1);
    cycle();
    check("wrpop_level", fifo_level, 4);
    check("wrpop_drops", drop_count, 2);
    drain(300);

    // Reset in WAIT after the third byte abandons the frame
    do_reset();
    d_min = 3; d_max = 3;
    rst_at3 = 1;
    dir_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    i = 0;
    while (i < 100 && !rst_fired) begin
      cycle();
      i++;
    end
    check("midrst_fired", rst_fired, 1);
    cycle();
    check("midrst_tx_dv", tx_dv, 0);
    check("midrst_level", fifo_level, 0);
    run(10);
    log_q.delete();
    dir_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    run(2);
    drain(300);
    check("midrst_len", log_q.size(), 7);
    if (log_q.size() >= 2) begin
      check("midrst_sync", log_q[0], SYNC);
      check("midrst_seq", log_q[1], 0);
    end

    // Spurious tx_done while idle with a partial frame buffered
    do_reset();
    dir_q = '{8'h01, 8'h02, 8'h03};
    run(5);
    spur_done = 1;
    run(5);
    check("spur_level", fifo_level, 3);
    check("spur_tx_dv", tx_dv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
